// File: rtl/regfile_dump_if.sv
// Address/data beat stream from the register-file dump engine to the debug link.
// The master drives the beat; the slave answers with DumpReady.
interface regfile_dump_if #(
  parameter int width     = 32,
  parameter int addrWidth = 5
) ();
  logic                 DumpValid;
  logic                 DumpReady;
  logic [addrWidth-1:0] DumpAddr;
  logic [width-1:0]     DumpData;
  logic                 DumpLast;

  modport master (
    output DumpValid,
    output DumpAddr,
    output DumpData,
    output DumpLast,
    input  DumpReady
  );

  modport slave (
    input  DumpValid,
    input  DumpAddr,
    input  DumpData,
    input  DumpLast,
    output DumpReady
  );
endinterface

// File: rtl/regfile_dump.sv
// Register-file debug readout: walks an inclusive, wrapping address range through
// a borrowed read port and streams each register as one address/data beat.
module regfile_dump #(
  parameter int width     = 32,
  parameter int addrWidth = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [addrWidth-1:0] FirstReg,
  input  logic [addrWidth-1:0] LastReg,
  input  logic                 Grant,
  output logic                 Request,
  output logic [addrWidth-1:0] ReadRegister,
  input  logic [width-1:0]     ReadData,
  output logic                 Busy,
  output logic                 Done,
  regfile_dump_if.master       dump
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT                stateReg, stateNext;
  logic [addrWidth-1:0] ptrReg, ptrNext;
  logic [addrWidth-1:0] endReg, endNext;
  logic [addrWidth-1:0] dumpAddrReg, dumpAddrNext;
  logic [width-1:0]     dumpDataReg, dumpDataNext;
  logic                 dumpLastReg, dumpLastNext;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateReg    <= IDLE;
      ptrReg      <= '0;
      endReg      <= '0;
      dumpAddrReg <= '0;
      dumpDataReg <= '0;
      dumpLastReg <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      ptrReg      <= ptrNext;
      endReg      <= endNext;
      dumpAddrReg <= dumpAddrNext;
      dumpDataReg <= dumpDataNext;
      dumpLastReg <= dumpLastNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    ptrNext      = ptrReg;
    endNext      = endReg;
    dumpAddrNext = dumpAddrReg;
    dumpDataNext = dumpDataReg;
    dumpLastNext = dumpLastReg;
    case (stateReg)
      IDLE: begin
        if (Start) begin
          ptrNext   = FirstReg;
          endNext   = LastReg;
          stateNext = READ;
        end
      end
      READ: begin
        // The beat is captured here so a later Grant drop or file change cannot disturb it.
        if (Grant) begin
          dumpAddrNext = ptrReg;
          dumpDataNext = ReadData;
          dumpLastNext = (ptrReg == endReg);
          stateNext    = SEND;
        end
      end
      SEND: begin
        if (dump.DumpReady) begin
          if (dumpLastReg) begin
            stateNext = DONE;
          end else begin
            // Natural overflow of the pointer gives the modulo-depth wrap.
            ptrNext   = ptrReg + addrWidth'(1);
            stateNext = READ;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign Busy           = (stateReg == READ) || (stateReg == SEND);
  assign Request        = Busy;
  assign Done           = (stateReg == DONE);
  assign ReadRegister   = ptrReg;
  assign dump.DumpValid = (stateReg == SEND);
  assign dump.DumpAddr  = dumpAddrReg;
  assign dump.DumpData  = dumpDataReg;
  assign dump.DumpLast  = dumpLastReg;

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized scoreboard bench for regfile_dump: expected beats come from a plain
// modulo-range walk over a behavioural register-file array.
module tb_regfile_dump;
  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int BOUND = 3000;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic          Grant;
  logic          Request;
  logic          Busy;
  logic          Done;
  logic [AW-1:0] FirstReg;
  logic [AW-1:0] LastReg;
  logic [AW-1:0] ReadRegister;
  logic [W-1:0]  ReadData;
  logic [W-1:0]  regs [DEPTH];

  regfile_dump_if #(.width(W), .addrWidth(AW)) dumpIf ();

  regfile_dump #(.width(W), .addrWidth(AW)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .FirstReg     (FirstReg),
    .LastReg      (LastReg),
    .Grant        (Grant),
    .Request      (Request),
    .ReadRegister (ReadRegister),
    .ReadData     (ReadData),
    .Busy         (Busy),
    .Done         (Done),
    .dump         (dumpIf)
  );

  always #5 Clk = ~Clk;

  assign ReadData = regs[ReadRegister];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          last;
  } beatT;

  beatT sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   doneCount = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected beats of an inclusive, wrapping range, using the file contents at issue time.
  task automatic pushRange(input int first, input int last);
    int n;
    n = ((last - first) % DEPTH + DEPTH) % DEPTH + 1;
    for (int i = 0; i < n; i++) begin
      int a;
      a = (first + i) % DEPTH;
      sb.push_back('{addr: AW'(a), data: regs[a], last: (i == n - 1)});
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic runDump(input int first, input int last, input int gP, input int rP,
                         input int stall, input int holdAddr, input int startNoise,
                         input int expCycles);
    int  cycles;
    int  holds;
    int  doneBefore;
    bit  finished;
    pushRange(first, last);
    doneBefore = doneCount;
    FirstReg   = AW'(first);
    LastReg    = AW'(last);
    Start      = 1'b1;
    tick();
    cycles   = 0;
    holds    = 0;
    finished = 1'b0;
    while (!finished) begin
      FirstReg = AW'($urandom_range(DEPTH - 1));
      LastReg  = AW'($urandom_range(DEPTH - 1));
      Start    = (startNoise != 0) && ($urandom_range(1) == 1);
      Grant    = ($urandom_range(99) < gP) && (cycles >= stall);
      if (holdAddr >= 0 && dumpIf.DumpValid && dumpIf.DumpAddr == AW'(holdAddr) && holds < 4) begin
        if (holds == 0) regs[holdAddr] = ~regs[holdAddr];
        Grant            = 1'b0;
        dumpIf.DumpReady = 1'b0;
        holds++;
      end else begin
        dumpIf.DumpReady = ($urandom_range(99) < rP);
      end
      @(negedge Clk);
      cycles++;
      if (cycles == 1) begin
        chk("busy in first READ", Busy, 1);
        chk("request in first READ", Request, 1);
      end
      if (cycles <= stall) begin
        chk("valid while grant low", dumpIf.DumpValid, 0);
        chk("read address while grant low", ReadRegister, first);
        chk("request while grant low", Request, 1);
      end
      if (stall > 0 && cycles == stall + 2) chk("valid after grant", dumpIf.DumpValid, 1);
      if (Done) begin
        finished = 1'b1;
      end else if (cycles >= BOUND) begin
        chk("dump timeout cycles", cycles, BOUND + 1);
        finished = 1'b1;
      end else begin
        tick();
      end
    end
    if (expCycles >= 0) chk("cycles to Done", cycles, expCycles);
    if (holdAddr >= 0) chk("backpressure cycles", holds, 4);
    tick();
    Start            = 1'b0;
    Grant            = 1'b0;
    dumpIf.DumpReady = 1'b0;
    @(negedge Clk);
    chk("busy after Done (no restart)", Busy, 0);
    chk("done pulses for dump", doneCount - doneBefore, 1);
    tick();
  endtask

  initial begin
    fork
      begin : monitor
        beatT prev;
        beatT got;
        beatT exp;
        logic prevHold;
        prevHold = 1'b0;
        prev     = '0;
        forever begin
          @(negedge Clk);
          if (Reset) begin
            prevHold = 1'b0;
          end else begin
            got = '{addr: dumpIf.DumpAddr, data: dumpIf.DumpData, last: dumpIf.DumpLast};
            if (prevHold && dumpIf.DumpValid) begin
              chk("held addr", got.addr, prev.addr);
              chk("held data", got.data, prev.data);
              chk("held last", got.last, prev.last);
            end
            if (dumpIf.DumpValid && dumpIf.DumpReady) begin
              if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected beat: got addr %0d data 0x%0h, expected no beat",
                         got.addr, got.data);
              end else begin
                exp = sb.pop_front();
                $display("beat addr=%0d data=0x%08h last=%0b", got.addr, got.data, got.last);
                chk("beat addr", got.addr, exp.addr);
                chk("beat data", got.data, exp.data);
                chk("beat last", got.last, exp.last);
              end
            end
            prevHold = dumpIf.DumpValid && !dumpIf.DumpReady;
            prev     = got;
            if (Done) begin
              doneCount++;
              chk("beats pending at Done", sb.size(), 0);
            end
          end
        end
      end
      begin : stimulus
        int doneBefore;
        bit found;
        Reset            = 1'b1;
        Start            = 1'b0;
        Grant            = 1'b0;
        FirstReg         = '0;
        LastReg          = '0;
        dumpIf.DumpReady = 1'b0;
        for (int i = 0; i < DEPTH; i++) regs[i] = $urandom;
        regs[3] = 32'h11;
        regs[4] = 32'h22;
        regs[5] = 32'h33;
        tick();
        tick();
        @(negedge Clk);
        chk("reset Request", Request, 0);
        chk("reset Busy", Busy, 0);
        chk("reset DumpValid", dumpIf.DumpValid, 0);
        chk("reset DumpLast", dumpIf.DumpLast, 0);
        chk("reset Done", Done, 0);
        chk("reset ReadRegister", ReadRegister, 0);
        chk("reset DumpAddr", dumpIf.DumpAddr, 0);
        chk("reset DumpData", dumpIf.DumpData, 0);
        tick();
        Reset = 1'b0;
        tick();

        // first, last, grant%, ready%, stall, holdAddr, startNoise, expected cycles
        runDump(3, 5, 100, 100, 0, -1, 0, 7);
        runDump(30, 1, 100, 100, 0, -1, 1, 9);
        runDump(7, 7, 100, 100, 0, -1, 1, 3);
        runDump(10, 12, 100, 100, 5, -1, 0, 12);
        runDump(3, 5, 100, 100, 0, 4, 1, 11);
        runDump(0, 31, 80, 50, 0, -1, 1, -1);
        runDump(5, 4, 100, 100, 0, -1, 0, 65);
        for (int r = 0; r < 4; r++) begin
          for (int i = 0; i < DEPTH; i++) regs[i] = $urandom;
          runDump($urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1), 70, 60, 0, -1, 1, -1);
        end

        // Reset while beat 2 of 4 is being presented.
        pushRange(8, 11);
        doneBefore = doneCount;
        FirstReg   = AW'(8);
        LastReg    = AW'(11);
        Start      = 1'b1;
        tick();
        Grant            = 1'b1;
        dumpIf.DumpReady = 1'b1;
        found            = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
          Start = ($urandom_range(1) == 1);
          if (dumpIf.DumpValid && dumpIf.DumpAddr == AW'(9)) begin
            found            = 1'b1;
            Reset            = 1'b1;
            Start            = 1'b0;
            dumpIf.DumpReady = 1'b0;
          end else begin
            tick();
          end
        end
        chk("reached beat 2 before reset", found, 1);
        tick();
        Reset = 1'b0;
        sb.delete();
        @(negedge Clk);
        chk("mid-dump reset DumpValid", dumpIf.DumpValid, 0);
        chk("mid-dump reset Busy", Busy, 0);
        chk("mid-dump reset Request", Request, 0);
        chk("mid-dump reset Done", Done, 0);
        chk("mid-dump reset DumpAddr", dumpIf.DumpAddr, 0);
        chk("mid-dump reset DumpData", dumpIf.DumpData, 0);
        for (int c = 0; c < 4; c++) tick();
        chk("no Done after mid-dump reset", doneCount - doneBefore, 0);

        runDump(28, 2, 90, 70, 0, -1, 1, -1);
        chk("leftover expected beats", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join_any
  end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug readout engine for the register file. On a start pulse it takes over a register-file read port, walks an inclusive, wrapping address range, and streams each register as an address/data beat over a valid/ready interface to the debug link. It sits beside the core's register file and reads it while the core is frozen.

## Interface
- width, 32, register data width
- addrWidth, 5, register address width; depth = 2**addrWidth
- Clk  in  1  clock, all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  begin a dump; sampled only in IDLE
- FirstReg  in  addrWidth  first register of range; captured on accepted Start
- LastReg  in  addrWidth  last register of range (inclusive); captured on accepted Start
- Grant  in  1  core frozen; read port is owned by this block this cycle
- Request  out  1  asks core to freeze and grant the read port
- ReadRegister  out  addrWidth  register-file read address
- ReadData  in  width  combinational register-file read data for ReadRegister
- DumpValid  out  1  beat available
- DumpReady  in  1  sink accepts beat
- DumpAddr  out  addrWidth  register index of current beat
- DumpData  out  width  register value of current beat
- DumpLast  out  1  current beat is the final one of the range
- Busy  out  1  dump in progress
- Done  out  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: Start=1 -> latch ptr=FirstReg, end=LastReg; -> READ. Otherwise stay.
- READ: ReadRegister=ptr. Grant=1 -> register DumpAddr=ptr, DumpData=ReadData, DumpLast=(ptr==end); -> SEND. Grant=0 -> stay (stall indefinitely, no beat produced).
- SEND: DumpValid=1. DumpValid&DumpReady -> if DumpLast go to DONE, else ptr=ptr+1 mod depth, go to READ. Otherwise hold.
- DONE: Done=1 for exactly one cycle; -> IDLE.
- Range: ptr increments modulo depth; FirstReg>LastReg wraps (e.g. 30..1 = 30,31,0,1). FirstReg==LastReg gives one beat. Full sweep: FirstReg=0, LastReg=depth-1 (32 beats); also FirstReg=LastReg+1 mod depth.
- Request=Busy=1 in READ and SEND; 0 in IDLE and DONE.
- Register 0 is read and reported like any other (value from file, normally 0).
- Start outside IDLE ignored, including DONE. FirstReg/LastReg changes after acceptance ignored.
- Beat stability: while DumpValid=1 and DumpReady=0, DumpAddr/DumpData/DumpLast held constant; Grant dropping during SEND has no effect on the held beat.
- Block never writes the register file.

## Timing
- Reset (sync): state IDLE; Request, Busy, DumpValid, DumpLast, Done = 0; ReadRegister, DumpAddr, ptr = 0; DumpData = 0.
- Reset asserted mid-dump: next edge returns to IDLE with all reset values; pending beat dropped, no Done.
- Start accepted at edge k: Busy/Request=1 during cycle k+1 (READ).
- Grant=1 in READ during cycle c: DumpValid=1 from cycle c+1.
- Handshake at edge h, not last: READ in cycle h+1, DumpValid=0 for that cycle at minimum.
- Throughput with Grant and DumpReady held high: one beat per 2 cycles; N-beat dump takes 2N cycles from first READ to final handshake, Done in the following cycle.
- Final handshake at edge h: Done=1, Busy=0 during cycle h+1; IDLE in cycle h+2, Start accepted there at earliest.
- All outputs registered or decoded from state only; no combinational path from DumpReady or Grant to any output.

## Test plan
- Reset then Start with FirstReg=3, LastReg=5, Grant=1, DumpReady=1, regs r3..r5=0x11,0x22,0x33 -> beats (3,0x11),(4,0x22),(5,0x33,Last), one beat per 2 cycles, Done pulse 1 cycle after third handshake.
- Wrap: FirstReg=30, LastReg=1 -> DumpAddr sequence 30,31,0,1, DumpLast only on addr 1; FirstReg=LastReg=7 -> single beat, Last=1.
- Grant low 5 cycles in READ -> no DumpValid, ReadRegister stable, Request=1; Grant raised -> beat appears next cycle with correct data.
- Backpressure: DumpReady low 4 cycles on beat addr 4 -> DumpAddr/DumpData/DumpLast unchanged; change r4 and drop Grant meanwhile -> held value still the originally captured one.
- Full sweep FirstReg=0, LastReg=31 with random DumpReady -> exactly 32 beats, addresses 0..31 in order, data matches file, one Done.
- Reset asserted during SEND of beat 2 of 4 -> next cycle DumpValid=0, Busy=0, no Done; Start pulses during READ/SEND/DONE ignored.
